shreg_tx_ctrl: RTL
==================

Name: shreg_tx_ctrl

Overview:
Transmit sequencer for the team's 4-bit shift-register datapath. It accepts parallel words over a valid/ready handshake and serializes each word onto a single-bit line, MSB- or LSB-first. Bit order and an inter-word idle gap are latched per word. It sits between a parallel producer and a serial consumer, and owns the only loadable shift register on that path.

Parameters:
WIDTH, 4, bits per word; legal range >= 2.
GAP_W, 4, width of gap config field (max gap 2^GAP_W-1 cycles).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block accepts word this cycle
in_data  input  WIDTH  parallel word
msb_first  input  1  bit order for the word being accepted
gap  input  GAP_W  idle cycles after the word being accepted
abort  input  1  synchronous cancel of current word
so  output  1  serial data bit
so_valid  output  1  so carries a data bit
frame_start  output  1  first bit of a word on so
done  output  1  last bit of a word on so
busy  output  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low, immediately: state=IDLE; shift reg, bit counter, gap counter = 0; so=0, so_valid=0, frame_start=0, done=0, busy=0, in_ready=0.
- in_ready is gated by a ready-enable flop that is cleared by reset and set on the first clk edge after rst_n rises.
- States: IDLE, SHIFT, GAP.
- in_ready = rdy_en && !abort && (IDLE || (SHIFT && last_bit && gap_q==0)).
- Accept = in_valid && in_ready at edge k: load in_data, latch msb_first, latch gap into gap_q, clear bit counter, state=SHIFT. The first bit is on so in cycle k+1 (one-cycle latency).
- SHIFT: so = msb_q ? sreg[WIDTH-1] : sreg[0]; so_valid=1.
  - frame_start=1 when bit counter==0.
  - Each edge shifts toward the output end and increments the counter.
  - last_bit = counter==WIDTH-1; done=1 in that cycle.
- Exit from last_bit:
  - Accept in the same cycle: reload, stay in SHIFT. No bubble.
  - gap_q>0: GAP, gap counter=0.
  - Otherwise: IDLE.
- GAP: so=0, so_valid=0, in_ready=0. After gap_q cycles in GAP, go to IDLE.
- abort=1 in SHIFT or GAP: next state IDLE, shift reg cleared, no done pulse for the cancelled word. abort in IDLE has no effect except forcing in_ready=0, so abort wins over a simultaneous in_valid.
- msb_first, gap and in_data changes outside the accept cycle are ignored.
- in_valid with in_ready=0 is held off; the block never drops a word.
- Counters use clog2(WIDTH) and GAP_W bits. No wrap beyond terminal count.
- so is driven from registered state only; no combinational path from in_data to so.
- Outputs when not in SHIFT: so=0, so_valid=0, frame_start=0, done=0.

Decomposition:
- Package shreg_pkg:
  - state enum typedef (IDLE, SHIFT, GAP)
  - default WIDTH/GAP_W constants
- Sub-module shreg_piso_dir:
  - loadable WIDTH-bit shift register with load, shift_en, dir (msb/lsb) and clear inputs, and a serial output.
  - Async active-low reset.
- The controller FSM, counters and handshake live in shreg_tx_ctrl.

Test Plan:
1. Reset release, in_data=4'b1011, msb_first=1, gap=0 -> accept at first ready edge. Next 4 cycles: so=1,0,1,1 with so_valid=1, frame_start on bit 1, done on bit 4. Then IDLE, in_ready=1.
2. in_data=4'b1011, msb_first=0 -> so=1,1,0,1. frame_start/done on bits 1 and 4.
3. in_data=4'hC, gap=2 -> 4 bits 1,1,0,0, then 2 cycles with so_valid=0 and in_ready=0. in_ready=1 on the following cycle.
4. Back-to-back, gap=0, in_valid held with 4'hA then 4'h5, msb_first=1 -> 8 contiguous so_valid cycles 1,0,1,0,0,1,0,1. frame_start at bits 1 and 5, done at bits 4 and 8. in_ready=1 during bit 4.
5. abort=1 during bit 2 of 4'hF -> next cycle so_valid=0, busy=0, no done pulse. A new word is then accepted normally.
6. rst_n low during bit 3 -> so, so_valid, busy, in_ready go 0 immediately, without a clock. After release, in_ready=0 in the first cycle and 1 from the second.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared types and default sizing for the serial transmit path.
package shreg_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/shreg_piso_dir.sv
// Loadable parallel-in / serial-out shift register with selectable direction.
// dir=1 presents and shifts from the MSB end, dir=0 from the LSB end.
module shreg_piso_dir #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             clear,
  output logic             sout
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  // Next contents: clear beats load, load beats shift.
  always_comb begin
    sreg_d = sreg_q;
    if (clear) begin
      sreg_d = '0;
    end else if (load) begin
      sreg_d = load_data;
    end else if (shift_en) begin
      if (dir) begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign sout = dir ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/shreg_tx_ctrl.sv
// Transmit sequencer: accepts parallel words over valid/ready and serializes
// them onto so, with per-word bit order and an optional idle gap afterwards.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight, ready for a word once rdy_en_q is set
// ST_SHIFT | one bit per cycle on so; next word may load on the last bit
// ST_GAP   | idle gap of gap_q cycles after a word, handshake held off
module shreg_tx_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             msb_q;
  logic             rdy_en_q;

  logic             in_shift;
  logic             last_bit;
  logic             accept;
  logic             cancel;
  logic             sreg_out;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = in_shift && (bit_cnt_q == LAST_CNT);
  assign cancel   = abort && (state_q != ST_IDLE);

  // Handshake: abort always wins, and a reload on the last bit is only
  // offered when no gap follows the current word.
  assign in_ready = rdy_en_q && !abort &&
                    ((state_q == ST_IDLE) || (last_bit && (gap_q == '0)));
  assign accept   = in_valid && in_ready;

  // Controller FSM with bit and gap counters and the per-word latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_q     <= '0;
      msb_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        state_q   <= ST_SHIFT;
        bit_cnt_q <= '0;
        gap_cnt_q <= '0;
        gap_q     <= gap;
        msb_q     <= msb_first;
      end else if (cancel) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        gap_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (last_bit) begin
              bit_cnt_q <= '0;
              gap_cnt_q <= '0;
              state_q   <= (gap_q != '0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          ST_GAP: begin
            // gap_q is non-zero whenever this state is entered.
            if (gap_cnt_q == (gap_q - GAP_W'(1))) begin
              gap_cnt_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  shreg_piso_dir #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_data(in_data),
    .shift_en (in_shift && !accept),
    .dir      (msb_q),
    .clear    (cancel),
    .sout     (sreg_out)
  );

  // Serial outputs decode registered state only; a cancelled word never
  // reports done, even when aborted on its last bit.
  assign so          = in_shift && sreg_out;
  assign so_valid    = in_shift;
  assign frame_start = in_shift && (bit_cnt_q == '0);
  assign done        = last_bit && !abort;
  assign busy        = (state_q != ST_IDLE);

endmodule
